// File: rtl/mxv_round_scheduler.sv
// Round scheduler for a matrix-by-vector engine: prefetch, issue lanes, wait for completion, drain.
// Optional watchdog on the WAIT state is enabled by defining MXV_SCHED_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no job; waits for start high
// PREFETCH | one-cycle operand prefetch request (skipped when no rows remain)
// ISSUE    | one-cycle lane start pulses for the current row group
// WAIT     | collect lane_done until every lane of the round is done
// DRAIN    | DRAIN_CYCLES flush cycles before finishing
// DONE     | finish held high until start drops
module mxv_round_scheduler #(
   parameter int NO_OF_LANES    = 4,
   parameter int DRAIN_CYCLES   = 6,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            total_rows,
   input  logic [NO_OF_LANES-1:0] lane_done,
   output logic                   mem_prefetch,
   output logic [NO_OF_LANES-1:0] lane_start,
   output logic [31:0]            round_index,
   output logic                   busy,
   output logic                   finish,
   output logic                   overrun,
   output logic                   timeout
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PREFETCH, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t                 state;
   logic [31:0]            rows_left;
   logic [NO_OF_LANES-1:0] done_mask;
   logic [DCW-1:0]         drain_cnt;
   logic [31:0]            issue_cnt;
   logic [NO_OF_LANES-1:0] issue_mask;

`ifdef MXV_SCHED_TIMEOUT_EN
   localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TCW-1:0] wd_cnt;
`else
   // Constant 0; the comparison only keeps the parameter referenced in this build.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      issue_cnt  = (rows_left < 32'(NO_OF_LANES)) ? rows_left : 32'(NO_OF_LANES);
      issue_mask = '0;
      for (int k = 0; k < NO_OF_LANES; k++) begin
         if (32'(k) < issue_cnt) issue_mask[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         mem_prefetch <= 1'b0;
         lane_start   <= '0;
         round_index  <= '0;
         busy         <= 1'b0;
         finish       <= 1'b0;
         overrun      <= 1'b0;
         rows_left    <= '0;
         done_mask    <= '0;
         drain_cnt    <= '0;
`ifdef MXV_SCHED_TIMEOUT_EN
         timeout      <= 1'b0;
         wd_cnt       <= '0;
`endif
      end else begin
         mem_prefetch <= 1'b0;
         lane_start   <= '0;
         if (state != S_IDLE && !start) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            finish    <= 1'b0;
            done_mask <= '0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  state        <= S_PREFETCH;
                  rows_left    <= total_rows;
                  round_index  <= '0;
                  done_mask    <= '0;
                  overrun      <= 1'b0;
                  busy         <= 1'b1;
                  mem_prefetch <= (total_rows != 32'd0);
`ifdef MXV_SCHED_TIMEOUT_EN
                  timeout      <= 1'b0;
`endif
               end
               S_PREFETCH: if (rows_left == 32'd0) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DCW'(DRAIN_CYCLES - 1);
               end else begin
                  // Unstarted lanes are pre-marked done so a short last round completes early.
                  state       <= S_ISSUE;
                  lane_start  <= issue_mask;
                  done_mask   <= ~issue_mask;
                  rows_left   <= rows_left - issue_cnt;
                  round_index <= round_index + 32'd1;
               end
               S_ISSUE: begin
                  if ((lane_done & done_mask) != '0) overrun <= 1'b1;
                  state <= S_WAIT;
`ifdef MXV_SCHED_TIMEOUT_EN
                  wd_cnt <= TCW'(TIMEOUT_CYCLES - 1);
`endif
               end
               S_WAIT: begin
                  if ((lane_done & done_mask) != '0) overrun <= 1'b1;
                  if (&done_mask) begin
                     done_mask <= '0;
                     if (rows_left != 32'd0) begin
                        state        <= S_PREFETCH;
                        mem_prefetch <= 1'b1;
                     end else begin
                        state     <= S_DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                     end
                  end else begin
                     done_mask <= done_mask | lane_done;
`ifdef MXV_SCHED_TIMEOUT_EN
                     if (wd_cnt == '0) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                     end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                     end
`endif
                  end
               end
               S_DRAIN: if (drain_cnt == '0) begin
                  state  <= S_DONE;
                  finish <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
               S_DONE: finish <= 1'b1;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mxv_round_scheduler.sv
// Self-checking bench for mxv_round_scheduler: vector table, random jobs against a round-level model,
// and hand-written abort / reset / overrun / watchdog sequences.
module tb_mxv_round_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] total_rows = '0;
   logic [3:0]  lane_done = '0;
   logic        mem_prefetch;
   logic [3:0]  lane_start;
   logic [31:0] round_index;
   logic        busy, finish, overrun, timeout;

   int n_vec = 0;
   int n_err = 0;

   mxv_round_scheduler #(.NO_OF_LANES(4), .DRAIN_CYCLES(6), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .start(start), .total_rows(total_rows), .lane_done(lane_done),
      .mem_prefetch(mem_prefetch), .lane_start(lane_start), .round_index(round_index),
      .busy(busy), .finish(finish), .overrun(overrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         rows;
      int         dly;
      int         exp_rounds;
      int         exp_done;
      logic [3:0] exp_last;
   } vec_t;

   int         dly[8][4];
   bit         extra2;
   int         g_rounds, g_prefetch, g_done, g_first_issue, g_overlap, g_busy_err, g_mask_err;
   logic [3:0] g_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion cycle from the round structure: each round costs prefetch + issue + (slowest lane + 1) wait.
   function automatic int model_done(input int rows);
      int sum, rem, d;
      if (rows == 0) return 8;
      sum = 1;
      for (int r = 0; r < (rows + 3) / 4; r++) begin
         rem = rows - 4 * r;
         d = 0;
         for (int k = 0; k < 4 && k < rem; k++) if (dly[r][k] > d) d = dly[r][k];
         sum += d + 3;
      end
      return sum + 6;
   endfunction

   task automatic run_job(input int rows);
      int pending[4];
      int extra_at, rnd, rem;
      logic [3:0] exp_mask;
      pending = '{-1, -1, -1, -1};
      extra_at = -1; rnd = 0;
      g_prefetch = 0; g_done = -1; g_first_issue = 0; g_overlap = 0; g_busy_err = 0; g_mask_err = 0;
      g_last = '0;
      total_rows = 32'(rows);
      start = 1'b1;
      for (int n = 1; n <= 400 && g_done < 0; n++) begin
         tick();
         if (mem_prefetch) g_prefetch++;
         if (mem_prefetch && lane_start != '0) g_overlap++;
         if (lane_start != '0) begin
            rem = rows - 4 * rnd;
            exp_mask = '0;
            for (int k = 0; k < 4; k++) if (k < rem) exp_mask[k] = 1'b1;
            if (lane_start !== exp_mask) g_mask_err++;
            if (rnd == 0) g_first_issue = n;
            for (int k = 0; k < 4; k++) if (lane_start[k]) pending[k] = n + dly[rnd % 8][k];
            if (extra2 && rnd == 0) extra_at = pending[2] + 1;
            g_last = lane_start;
            rnd++;
         end
         if (finish) g_done = n;
         else if (!busy) g_busy_err++;
         for (int k = 0; k < 4; k++) lane_done[k] = (pending[k] == n) || (k == 2 && extra_at == n);
      end
      lane_done = '0;
      g_rounds = rnd;
   endtask

   task automatic check_job(input int rows, input int exp_rounds, input int exp_done, input logic exp_ovr);
      check("rounds", 32'(g_rounds), 32'(exp_rounds));
      check("prefetches", 32'(g_prefetch), 32'(exp_rounds));
      check("round_index", round_index, 32'(exp_rounds));
      check("done_cycle", 32'(g_done), 32'(exp_done));
      check("first_issue", 32'(g_first_issue), (rows > 0) ? 32'd2 : 32'd0);
      check("lane_mask", 32'(g_mask_err), 32'd0);
      check("prefetch_issue_overlap", 32'(g_overlap), 32'd0);
      check("busy_during_job", 32'(g_busy_err), 32'd0);
      check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      check("timeout_job", {31'd0, timeout}, 32'd0);
   endtask

   task automatic end_job();
      start = 1'b0;
      tick();
      check("finish_clear", {31'd0, finish}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      tick();
   endtask

   vec_t tbl[7];
   int   rows, cnt, fin;

   initial begin
      tbl[0] = '{rows: 8, dly: 3, exp_rounds: 2, exp_done: 19, exp_last: 4'b1111};
      tbl[1] = '{rows: 6, dly: 2, exp_rounds: 2, exp_done: 17, exp_last: 4'b0011};
      tbl[2] = '{rows: 0, dly: 1, exp_rounds: 0, exp_done: 8,  exp_last: 4'b0000};
      tbl[3] = '{rows: 1, dly: 1, exp_rounds: 1, exp_done: 11, exp_last: 4'b0001};
      tbl[4] = '{rows: 4, dly: 5, exp_rounds: 1, exp_done: 15, exp_last: 4'b1111};
      tbl[5] = '{rows: 9, dly: 1, exp_rounds: 3, exp_done: 19, exp_last: 4'b0001};
      tbl[6] = '{rows: 5, dly: 4, exp_rounds: 2, exp_done: 21, exp_last: 4'b0001};
      extra2 = 1'b0;

      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_finish", {31'd0, finish}, 32'd0);
      check("rst_prefetch", {31'd0, mem_prefetch}, 32'd0);
      check("rst_lane_start", {28'd0, lane_start}, 32'd0);
      check("rst_round_index", round_index, 32'd0);
      check("rst_flags", {30'd0, overrun, timeout}, 32'd0);
      reset = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 7; i++) begin
         for (int r = 0; r < 8; r++) for (int k = 0; k < 4; k++) dly[r][k] = tbl[i].dly;
         run_job(tbl[i].rows);
         check_job(tbl[i].rows, tbl[i].exp_rounds, tbl[i].exp_done, 1'b0);
         check("tbl_last_mask", {28'd0, g_last}, {28'd0, tbl[i].exp_last});
         end_job();
      end

      for (int j = 0; j < 20; j++) begin
         rows = int'($urandom_range(0, 22));
         for (int r = 0; r < 8; r++) for (int k = 0; k < 4; k++) dly[r][k] = int'($urandom_range(1, 6));
         run_job(rows);
         check_job(rows, (rows + 3) / 4, model_done(rows), 1'b0);
         end_job();
      end

      // Lane 2 reports done twice in one round.
      for (int k = 0; k < 4; k++) dly[0][k] = 3;
      dly[0][2] = 1;
      extra2 = 1'b1;
      run_job(4);
      check_job(4, 1, 13, 1'b1);
      extra2 = 1'b0;
      end_job();
      total_rows = 32'd0;
      start = 1'b1;
      tick();
      check("overrun_cleared_on_start", {31'd0, overrun}, 32'd0);
      end_job();

      // Abort while waiting in round 1.
      total_rows = 32'd8;
      start = 1'b1;
      tick(); tick();
      check("abort_issue_mask", {28'd0, lane_start}, 32'hF);
      tick();
      check("abort_busy_wait", {31'd0, busy}, 32'd1);
      start = 1'b0;
      tick();
      check("abort_busy", {31'd0, busy}, 32'd0);
      cnt = 0;
      repeat (6) begin
         if (lane_start != '0 || mem_prefetch || finish) cnt++;
         tick();
      end
      check("abort_quiet", 32'(cnt), 32'd0);

      // Reset asserted in the middle of DRAIN.
      total_rows = 32'd3;
      start = 1'b1;
      tick(); tick();
      check("rst_job_issue", {28'd0, lane_start}, 32'h7);
      tick();
      lane_done = 4'b0111;
      tick();
      lane_done = '0;
      tick(); tick();
      check("drain_busy", {31'd0, busy}, 32'd1);
      check("drain_round_index", round_index, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_round_index", round_index, 32'd0);
      check("async_outputs", {28'd0, mem_prefetch, finish, overrun, timeout}, 32'd0);
      start = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("post_reset_idle", {31'd0, busy}, 32'd0);

      // Lane 3 never completes.
      total_rows = 32'd4;
      start = 1'b1;
      fin = -1;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (finish && fin < 0) fin = n;
         lane_done = (n == 3) ? 4'b0111 : 4'b0000;
      end
      lane_done = '0;
`ifdef MXV_SCHED_TIMEOUT_EN
      check("wd_finish_cycle", 32'(fin), 32'd19);
      check("wd_timeout", {31'd0, timeout}, 32'd1);
      check("wd_busy", {31'd0, busy}, 32'd0);
`else
      check("wd_finish_cycle", 32'(fin), 32'hFFFF_FFFF);
      check("wd_timeout", {31'd0, timeout}, 32'd0);
      check("wd_busy", {31'd0, busy}, 32'd1);
`endif
      end_job();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mxv_round_scheduler.md
MXV_ROUND_SCHEDULER -- requirements
Module: mxv_round_scheduler

Interface
REQ-001 Parameters SHALL be: NO_OF_LANES, default 4, number of row-by-vector lanes sequenced; DRAIN_CYCLES, default 6, post-compute flush cycles before finish; TIMEOUT_CYCLES, default 1024, watchdog limit per round.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level job enable; high = run, low = abort/idle.
REQ-005 total_rows  input  32  number of matrix rows in the job, sampled only on IDLE->PREFETCH.
REQ-006 lane_done  input  NO_OF_LANES  per-lane one-cycle completion pulses; bit k = lane k.
REQ-007 mem_prefetch  output  1  one-cycle pulse requesting operand memories to load the next row group.
REQ-008 lane_start  output  NO_OF_LANES  one-cycle per-lane start pulses.
REQ-009 round_index  output  32  number of rounds issued in the current job.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 finish  output  1  job complete; held high in DONE.
REQ-012 overrun  output  1  sticky flag: lane_done received on a lane already marked done in the current round.
REQ-013 timeout  output  1  sticky watchdog flag (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, PREFETCH, ISSUE, WAIT, DRAIN, DONE.
REQ-015 IDLE->PREFETCH when start=1; capture rows_left=total_rows, clear round_index, done_mask, overrun and timeout.
REQ-016 PREFETCH SHALL drive mem_prefetch=1 for exactly one cycle, then go to ISSUE; if rows_left=0 it SHALL go to DRAIN with no mem_prefetch.
REQ-017 ISSUE (one cycle) SHALL drive lane_start bit k=1 for k < min(rows_left, NO_OF_LANES), others 0; preload done_mask with 1s for unstarted lanes; rows_left -= started count (saturating at 0); round_index += 1; next state WAIT.
REQ-018 WAIT SHALL OR lane_done into done_mask each cycle; when the registered done_mask is all ones, it SHALL clear done_mask and go to PREFETCH if rows_left>0, else DRAIN.
REQ-019 lane_done on a bit already set in done_mask SHALL set overrun; lane_done outside WAIT SHALL be ignored except for overrun detection in ISSUE.
REQ-020 DRAIN SHALL count DRAIN_CYCLES cycles, then enter DONE; finish=1 from the first DONE cycle.
REQ-021 DONE SHALL hold finish=1 until start=0, then return to IDLE with finish=0 next cycle.
REQ-022 start=0 in any non-IDLE state SHALL force IDLE on the next edge; all pulses and finish SHALL be 0 in that cycle; flags hold until next job start.
REQ-023 Latency start rise -> first lane_start SHALL be 2 cycles (IDLE->PREFETCH->ISSUE).
REQ-024 Rounds issued SHALL equal ceil(total_rows/NO_OF_LANES); round_index arithmetic SHALL be 32-bit unsigned, wrapping not required.
REQ-025 mem_prefetch and lane_start SHALL never be high in the same cycle.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE and drive mem_prefetch=0, lane_start=0, round_index=0, busy=0, finish=0, overrun=0, timeout=0, clear done_mask, rows_left and drain counter.
REQ-027 Reset asserted mid-job SHALL abandon the job; after release the block SHALL need a new start level (start high in IDLE) to restart.

Configuration
REQ-028 Macro MXV_SCHED_TIMEOUT_EN: when defined, a counter SHALL run in WAIT, clearing on entry; reaching TIMEOUT_CYCLES SHALL set timeout and go to DONE (finish=1). When undefined, no counter SHALL exist, timeout SHALL be tied 0, WAIT may last indefinitely.

Verification
REQ-029 NO_OF_LANES=4, total_rows=8, all lanes pulse done 3 cycles after start pulse -> two lane_start=4'b1111 pulses, round_index=2, finish after 6 DRAIN cycles.
REQ-030 total_rows=6 -> round 1 lane_start=4'b1111, round 2 lane_start=4'b0011; round 2 ends on lanes 0,1 done only.
REQ-031 total_rows=0 -> no mem_prefetch, no lane_start, finish high 8 cycles after start rise.
REQ-032 Lane 2 pulses done twice in one round -> overrun=1 sticky, round still completes normally.
REQ-033 start dropped during WAIT of round 1 -> IDLE next edge, busy=0, no further lane_start; reset low mid-DRAIN -> all outputs 0 asynchronously.
REQ-034 With MXV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, lane 3 never done -> timeout=1 and finish=1 after 16 WAIT cycles; without macro, block stays in WAIT, timeout=0.
